// File: rtl/maxnet_controller.sv
// Maxnet winner-take-all sequencer: reads four activations, applies lateral
// inhibition, writes them back, and repeats until one survivor or MAX_ITER.
module maxnet_controller #(
  parameter int DATA_W    = 32,
  parameter int EPS_SHIFT = 2,
  parameter int MAX_ITER  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [1:0]        winner,
  output logic              winner_valid,
  output logic              timeout,
  output logic [7:0]        iter_count,
  output logic [1:0]        mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CALC,
    S_WRITE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [1:0]        r_idx;
  logic [DATA_W-1:0] r_a [4];

  logic [DATA_W+1:0] w_sum;
  logic [DATA_W+1:0] w_inh [4];
  logic [DATA_W-1:0] w_n   [4];
  logic [2:0]        w_nz;
  logic [1:0]        w_win;
  logic [7:0]        w_iter_next;

  // Sum is widened by two bits so four full-scale activations cannot overflow.
  always_comb begin
    w_sum = '0;
    for (int unsigned i = 0; i < 4; i++)
      w_sum = w_sum + {2'b00, r_a[i]};
    for (int unsigned i = 0; i < 4; i++) begin
      w_inh[i] = (w_sum - {2'b00, r_a[i]}) >> EPS_SHIFT;
      w_n[i]   = ({2'b00, r_a[i]} > w_inh[i]) ? r_a[i] - w_inh[i][DATA_W-1:0] : '0;
    end
  end

  always_comb begin
    w_nz  = '0;
    w_win = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (r_a[i] != '0) begin
        w_nz  = w_nz + 3'd1;
        w_win = 2'(i);
      end
    end
    w_iter_next = iter_count + 8'd1;
  end

  // Bus outputs decode the state register directly so mem_we clears as soon as rst does.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (r_state == S_READ) begin
      mem_addr = r_idx;
    end else if (r_state == S_WRITE) begin
      mem_addr  = r_idx;
      mem_we    = 1'b1;
      mem_wdata = r_a[r_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      for (int unsigned i = 0; i < 4; i++) r_a[i] <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      winner       <= '0;
      winner_valid <= 1'b0;
      timeout      <= 1'b0;
      iter_count   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state      <= S_READ;
            r_idx        <= '0;
            busy         <= 1'b1;
            iter_count   <= '0;
            winner       <= '0;
            winner_valid <= 1'b0;
            timeout      <= 1'b0;
          end
        end
        S_READ: begin
          r_a[r_idx] <= mem_rdata;
          r_idx      <= r_idx + 2'd1;
          if (r_idx == 2'd3) r_state <= S_CALC;
        end
        S_CALC: begin
          for (int unsigned i = 0; i < 4; i++) r_a[i] <= w_n[i];
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_idx <= r_idx + 2'd1;
          if (r_idx == 2'd3) r_state <= S_CHECK;
        end
        S_CHECK: begin
          iter_count <= w_iter_next;
          if (w_nz <= 3'd1) begin
            r_state      <= S_DONE;
            done         <= 1'b1;
            winner_valid <= (w_nz == 3'd1);
            winner       <= w_win;
          end else if (w_iter_next == 8'(MAX_ITER)) begin
            r_state      <= S_DONE;
            done         <= 1'b1;
            timeout      <= 1'b1;
            winner_valid <= 1'b0;
            winner       <= '0;
          end else begin
            r_state <= S_READ;
            r_idx   <= '0;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maxnet_controller.sv
// Directed bench for maxnet_controller: two instances (MAX_ITER 16 and 4)
// share one behavioural activation memory, selected per test.
module tb_maxnet_controller;

  typedef logic [31:0] row_t [4];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sel = 1'b0;
  logic        ld = 1'b0;
  row_t        ld_vals;
  logic [31:0] mem [4];
  row_t        traj [16];

  int n_checks = 0;
  int n_errors = 0;

  logic        busy_a, done_a, wv_a, to_a, we_a;
  logic [1:0]  win_a, addr_a;
  logic [7:0]  it_a;
  logic [31:0] wd_a;
  logic        busy_b, done_b, wv_b, to_b, we_b;
  logic [1:0]  win_b, addr_b;
  logic [7:0]  it_b;
  logic [31:0] wd_b;

  logic        busy_s, done_s, wv_s, to_s, we_s;
  logic [1:0]  win_s, addr_s;
  logic [7:0]  it_s;
  logic [31:0] wd_s;

  always #5 clk = ~clk;

  maxnet_controller #(.DATA_W(32), .EPS_SHIFT(2), .MAX_ITER(16)) dut_a (
    .clk(clk), .rst(rst), .start(start & ~sel),
    .busy(busy_a), .done(done_a), .winner(win_a), .winner_valid(wv_a),
    .timeout(to_a), .iter_count(it_a), .mem_addr(addr_a), .mem_we(we_a),
    .mem_wdata(wd_a), .mem_rdata(mem[addr_a])
  );

  maxnet_controller #(.DATA_W(32), .EPS_SHIFT(2), .MAX_ITER(4)) dut_b (
    .clk(clk), .rst(rst), .start(start & sel),
    .busy(busy_b), .done(done_b), .winner(win_b), .winner_valid(wv_b),
    .timeout(to_b), .iter_count(it_b), .mem_addr(addr_b), .mem_we(we_b),
    .mem_wdata(wd_b), .mem_rdata(mem[addr_b])
  );

  always_comb begin
    busy_s = sel ? busy_b : busy_a;
    done_s = sel ? done_b : done_a;
    wv_s   = sel ? wv_b   : wv_a;
    to_s   = sel ? to_b   : to_a;
    we_s   = sel ? we_b   : we_a;
    win_s  = sel ? win_b  : win_a;
    addr_s = sel ? addr_b : addr_a;
    it_s   = sel ? it_b   : it_a;
    wd_s   = sel ? wd_b   : wd_a;
  end

  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 4; i++) mem[i] <= ld_vals[i];
    end else if (we_s) begin
      mem[addr_s] <= wd_s;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic load_mem(input row_t v);
    @(negedge clk);
    ld_vals = v;
    ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
  endtask

  // Runs one activation sequence; cycle c is the cycle beginning at edge T+c.
  task automatic run_test(input bit b, input row_t init, input int nrows,
                          input logic [1:0] exp_w, input logic exp_v, input logic exp_to,
                          input int abort_c, input bit pulse);
    int ph;
    int row;
    logic [1:0] ea;
    logic       ew;
    sel = b;
    load_mem(init);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c <= 10 * nrows; c++) begin
      if (c > 0) @(negedge clk);
      start = pulse && (c == 2 || c == 6);
      if (c == abort_c) begin
        rst = 1'b1;
        #1;
        check("rst_busy", busy_s, 1'b0);
        check("rst_we", we_s, 1'b0);
        check("rst_done", done_s, 1'b0);
        check("rst_addr", addr_s, 2'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      check("busy", busy_s, 1'b1);
      check("done", done_s, c == 10 * nrows);
      if (c < 10 * nrows) begin
        ph  = c % 10;
        row = c / 10;
        ew  = (ph >= 5 && ph <= 8);
        ea  = (ph < 4) ? 2'(ph) : (ew ? 2'(ph - 5) : 2'd0);
        check("bus", {we_s, addr_s}, {ew, ea});
        if (ew) check("wdata", wd_s, traj[row][ph-5]);
        if (ph == 9)
          check("mem", {mem[0], mem[1], mem[2], mem[3]},
                {traj[row][0], traj[row][1], traj[row][2], traj[row][3]});
      end
    end
    check("winner", win_s, exp_w);
    check("winner_valid", wv_s, exp_v);
    check("timeout", to_s, exp_to);
    check("iter_count", it_s, 8'(nrows));
    @(negedge clk);
    check("busy_after", busy_s, 1'b0);
    check("done_after", done_s, 1'b0);
    check("winner_held", {wv_s, win_s}, {exp_v, exp_w});
    check("iter_held", it_s, 8'(nrows));
  endtask

  initial begin
    ld_vals = '{32'd0, 32'd0, 32'd0, 32'd0};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      sel = k[0];
      #1;
      check("reset_busy", busy_s, 1'b0);
      check("reset_done", done_s, 1'b0);
      check("reset_flags", {wv_s, to_s, win_s}, 4'd0);
      check("reset_iter", it_s, 8'd0);
      check("reset_bus", {we_s, addr_s, wd_s}, '0);
    end

    traj[0] = '{32'd0, 32'd0, 32'd13, 32'd25};
    traj[1] = '{32'd0, 32'd0, 32'd7,  32'd22};
    traj[2] = '{32'd0, 32'd0, 32'd2,  32'd21};
    traj[3] = '{32'd0, 32'd0, 32'd0,  32'd21};
    run_test(1'b0, '{32'd10, 32'd20, 32'd30, 32'd40}, 4, 2'd3, 1'b1, 1'b0, -1, 1'b1);

    traj[0] = '{32'd0, 32'd0, 32'd5, 32'd0};
    run_test(1'b0, '{32'd0, 32'd0, 32'd5, 32'd0}, 1, 2'd2, 1'b1, 1'b0, -1, 1'b0);

    traj[0] = '{32'd0, 32'd0, 32'd0, 32'd0};
    run_test(1'b0, '{32'd0, 32'd0, 32'd0, 32'd0}, 1, 2'd0, 1'b0, 1'b0, -1, 1'b0);

    traj[0] = '{32'd6, 32'd6, 32'd0, 32'd0};
    traj[1] = '{32'd5, 32'd5, 32'd0, 32'd0};
    traj[2] = '{32'd4, 32'd4, 32'd0, 32'd0};
    traj[3] = '{32'd3, 32'd3, 32'd0, 32'd0};
    run_test(1'b1, '{32'd8, 32'd8, 32'd0, 32'd0}, 4, 2'd0, 1'b0, 1'b1, -1, 1'b0);

    // Abort in the second WRITE cycle, then rerun from a reloaded memory.
    traj[0] = '{32'd0, 32'd0, 32'd13, 32'd25};
    traj[1] = '{32'd0, 32'd0, 32'd7,  32'd22};
    traj[2] = '{32'd0, 32'd0, 32'd2,  32'd21};
    traj[3] = '{32'd0, 32'd0, 32'd0,  32'd21};
    run_test(1'b0, '{32'd10, 32'd20, 32'd30, 32'd40}, 4, 2'd3, 1'b1, 1'b0, 6, 1'b0);
    check("post_rst_iter", it_a, 8'd0);
    check("post_rst_winner", {wv_a, to_a, win_a}, 4'd0);
    run_test(1'b0, '{32'd10, 32'd20, 32'd30, 32'd40}, 4, 2'd3, 1'b1, 1'b0, -1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/maxnet_controller.md
# maxnet_controller

Sequencer that runs the Maxnet winner-take-all iteration over the four-entry activation data memory. On `start` it repeatedly reads all four activations, applies lateral inhibition, and writes the results back. It stops when at most one activation is nonzero or when an iteration limit is reached, then reports the winning neuron index. It is the sole master of the data memory's address/write port and sits between the top-level control and the memory.

## Interface
- `DATA_W`, 32, activation width; unsigned integer.
- `EPS_SHIFT`, 2, inhibition weight epsilon = 2^-EPS_SHIFT (applied as a right shift).
- `MAX_ITER`, 16, maximum iterations before timeout; range 1..255.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin a run; sampled only in IDLE.
- `busy`  out  1  high from the cycle after start is accepted until DONE is left.
- `done`  out  1  one-cycle pulse in the DONE state.
- `winner`  out  2  index of the surviving neuron; held until the next start.
- `winner_valid`  out  1  exactly one nonzero activation at termination; held.
- `timeout`  out  1  run ended by MAX_ITER; held.
- `iter_count`  out  8  completed iterations of the current or last run.
- `mem_addr`  out  2  memory address (combinational read, synchronous write).
- `mem_we`  out  1  memory write enable.
- `mem_wdata`  out  DATA_W  write data.
- `mem_rdata`  in  DATA_W  read data for `mem_addr`, same cycle.

## Operation
- States:
  - IDLE.
  - READ: 4 cycles, idx 0..3.
  - CALC: 1 cycle.
  - WRITE: 4 cycles, idx 0..3.
  - CHECK: 1 cycle.
  - DONE: 1 cycle.
- IDLE: `start`=1 → READ, idx=0. On entry, clear `iter_count`, `winner`, `winner_valid` and `timeout`.
- READ: `mem_addr`=idx; capture `mem_rdata` into `a[idx]` at the edge; after idx 3 → CALC.
- CALC:
  - S = a0+a1+a2+a3, computed at DATA_W+2 bits with no overflow.
  - For each i: inh_i = (S − a_i) >> EPS_SHIFT.
  - n_i = (a_i > inh_i) ? a_i − inh_i : 0 (saturate at zero).
  - Register n into a; → WRITE.
- WRITE: `mem_addr`=idx, `mem_we`=1, `mem_wdata`=a[idx]; after idx 3 → CHECK.
- CHECK:
  - `iter_count`+1.
  - nz = count of nonzero a_i.
  - If nz ≤ 1 → DONE: `winner_valid`=(nz==1); `winner` = index of the nonzero entry, or 0 if none.
  - Else if the incremented count == MAX_ITER → DONE with `timeout`=1, `winner_valid`=0, `winner`=0.
  - Else → READ, idx=0.
- DONE: `done`=1 → IDLE.
- `start` is ignored while `busy`; it is level-sampled only in IDLE.
- Ties at the maximum never resolve; they terminate via timeout, or with all-zero (`winner_valid`=0).
- `mem_we` is high only in WRITE. `mem_addr` is 0 in IDLE, CALC, CHECK and DONE.

## Timing
- Reset values: state IDLE; all outputs 0; a[] cleared.
- `rst` mid-run forces IDLE immediately. `mem_we` drops asynchronously. A partially written memory is not repaired by this block; the memory's own reset reloads it.
- Each iteration takes 10 cycles (4+1+4+1).
- With start accepted at edge T: READ occupies cycles T..T+3.
- DONE (`done`=1) is the cycle starting at edge T+10·k, where k = final `iter_count`.
- `busy` falls with the exit from DONE.
- `start` held high through DONE starts a new run on the first IDLE cycle after it.

## Test plan
- Memory {10,20,30,40}, EPS_SHIFT=2, MAX_ITER=16:
  - Memory passes through {0,0,13,25}, {0,0,7,22}, {0,0,2,21}, then {0,0,0,21}.
  - Ends with `done`, `winner`=3, `winner_valid`=1, `iter_count`=4, `timeout`=0.
  - `done` is high 40 cycles after start acceptance.
- Memory {0,0,5,0} → one iteration, memory unchanged, `winner`=2, `winner_valid`=1, `iter_count`=1.
- Memory {0,0,0,0} → one iteration, `winner_valid`=0, `winner`=0, `timeout`=0.
- Memory {8,8,0,0}, MAX_ITER=4:
  - Memory passes through {6,6}, {5,5}, {4,4}, then {3,3}.
  - Ends with `timeout`=1, `winner_valid`=0, `iter_count`=4.
- `start` pulsed again during READ/WRITE → ignored, no iteration restart. `rst` asserted during the second WRITE cycle → `busy`, `mem_we` and `done` go to 0 the same cycle; the next `start` runs normally from the reloaded memory.
- Bus check on every iteration:
  - Addresses 0,1,2,3 are read, then 0,1,2,3 are written.
  - `mem_we` is high for exactly 4 cycles per iteration.
  - No write occurs in the READ, CALC or CHECK states.
